spi_core_arbiter: RTL

Round-robin arbiter and transaction sequencer that shares one spi_core instance between N requesters, e.g. several Avalon-side masters or internal engines. It captures the winning requester's 32-bit word and issues a single-cycle go_transfer pulse to the core. It then waits for data_pack_ready, returns the 32-bit read word to the winner, and guards every transfer with a timeout.

---
 rtl/spi_core_arbiter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/spi_core_arbiter.sv
// Round-robin arbiter that shares one spi_core between N_REQ requesters.
// Sequences go/wait/release for each transfer and aborts a silent core after TIMEOUT_CYCLES.
module spi_core_arbiter #(
    parameter int unsigned N_REQ          = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req,
    input  logic [32*N_REQ-1:0]  wdata,
    output logic [N_REQ-1:0]     gnt,
    output logic [N_REQ-1:0]     done,
    output logic [31:0]          rdata,
    output logic                 timeout_err,
    output logic                 busy,
    output logic                 spi_go,
    output logic [31:0]          spi_wdata,
    input  logic [31:0]          spi_rdata,
    input  logic                 spi_ready
);

    localparam int unsigned PTR_W = $clog2(N_REQ);
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_GO      = 2'd1;
    localparam logic [1:0] S_WAIT    = 2'd2;
    localparam logic [1:0] S_RELEASE = 2'd3;

    logic [1:0]       state, state_d;
    logic [PTR_W-1:0] ptr, ptr_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             ready_q;
    logic             rdy_rise;

    logic [N_REQ-1:0] gnt_d, done_d;
    logic [31:0]      rdata_d, spi_wdata_d;
    logic             timeout_err_d, busy_d, spi_go_d;

    logic [N_REQ-1:0] mask_lo, req_hi;
    logic [PTR_W-1:0] win_hi, win_any, win;
    logic [31:0]      wsel_hi, wsel_any, wsel;

    assign rdy_rise = spi_ready & ~ready_q;

    // Winner search: lowest set bit at or above ptr, else lowest set bit overall.
    always_comb begin
        win_hi   = '0;
        win_any  = '0;
        wsel_hi  = '0;
        wsel_any = '0;
        mask_lo  = (N_REQ'(1) << ptr) - N_REQ'(1);
        req_hi   = req & ~mask_lo;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (req[j]) begin
                win_any  = PTR_W'(j);
                wsel_any = wdata[32*j +: 32];
            end
            if (req_hi[j]) begin
                win_hi  = PTR_W'(j);
                wsel_hi = wdata[32*j +: 32];
            end
        end
        win  = (req_hi != '0) ? win_hi  : win_any;
        wsel = (req_hi != '0) ? wsel_hi : wsel_any;
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d       = state;
        ptr_d         = ptr;
        cnt_d         = cnt;
        gnt_d         = gnt;
        done_d        = done;
        rdata_d       = rdata;
        timeout_err_d = timeout_err;
        spi_go_d      = spi_go;
        spi_wdata_d   = spi_wdata;
        case (state)
            S_IDLE: begin
                spi_go_d = 1'b0;
                if ((req != '0) && !spi_ready) begin
                    gnt_d       = N_REQ'(1) << win;
                    spi_wdata_d = wsel;
                    spi_go_d    = 1'b1;
                    ptr_d       = (win == PTR_W'(N_REQ - 1)) ? '0 : win + 1'b1;
                    state_d     = S_GO;
                end
            end
            S_GO: begin
                spi_go_d = 1'b0;
                cnt_d    = '0;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                if (rdy_rise) begin
                    rdata_d = spi_rdata;
                    done_d  = gnt;
                    state_d = S_RELEASE;
                end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    rdata_d       = '0;
                    done_d        = gnt;
                    timeout_err_d = 1'b1;
                    state_d       = S_RELEASE;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            S_RELEASE: begin
                done_d        = '0;
                timeout_err_d = 1'b0;
                gnt_d         = '0;
                // A held data_pack_ready must fall before a new transfer may start.
                if (!spi_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            ptr         <= '0;
            cnt         <= '0;
            ready_q     <= 1'b0;
            gnt         <= '0;
            done        <= '0;
            rdata       <= '0;
            timeout_err <= 1'b0;
            busy        <= 1'b0;
            spi_go      <= 1'b0;
            spi_wdata   <= '0;
        end else begin
            state       <= state_d;
            ptr         <= ptr_d;
            cnt         <= cnt_d;
            ready_q     <= spi_ready;
            gnt         <= gnt_d;
            done        <= done_d;
            rdata       <= rdata_d;
            timeout_err <= timeout_err_d;
            busy        <= busy_d;
            spi_go      <= spi_go_d;
            spi_wdata   <= spi_wdata_d;
        end
    end

endmodule
